// File: rtl/frame_buffer_reader.sv
`timescale 1ns/1ps
// frame_buffer_reader
// Display-side reader of the frame buffer. It acts as an Avalon-MM burst read
// master: it fetches 64-bit words (two pixels each) from FB_ADDRESS, buffers
// them in a FIFO, and hands one pixel at a time to the LCD scanout logic.
// A frame_start pulse restarts the frame from pixel 0. A sticky underflow flag
// records when scanout asks for a pixel that memory has not yet delivered.
//
// Ports:
//   clock, reset_n         system clock, asynchronous active-low reset
//   address, burstcount,   Avalon read request (word address = byte addr / 8)
//   read, waitrequest
//   readdata,              Avalon read beats
//   readdatavalid
//   frame_start            one-cycle pulse that begins a new frame
//   pixel_ready            scanout consumes the current pixel this cycle
//   pixel_valid, red,      current pixel
//   green, blue
//   underflow              sticky scanout-starved flag
//   debug_value0           {underflow, 3'b0, state, fifo_count, words_remaining[15:0]}
module frame_buffer_reader #(
  parameter int unsigned FB_ADDRESS   = 0,
  parameter int unsigned FB_LENGTH    = 0,
  parameter int unsigned BURST_LENGTH = 16,
  parameter int unsigned FIFO_DEPTH   = 64
) (
  input  logic        clock,
  input  logic        reset_n,
  output logic [28:0] address,
  output logic [7:0]  burstcount,
  input  logic        waitrequest,
  input  logic [63:0] readdata,
  input  logic        readdatavalid,
  output logic        read,
  input  logic        frame_start,
  input  logic        pixel_ready,
  output logic        pixel_valid,
  output logic [7:0]  red,
  output logic [7:0]  green,
  output logic [7:0]  blue,
  output logic        underflow,
  output logic [31:0] debug_value0
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [28:0] BASE_WORD    = 29'(FB_ADDRESS / 8);
  localparam logic [31:0] FRAME_WORDS  = 32'(FB_LENGTH / 8);
  localparam logic [31:0] FRAME_PIXELS = 32'(FB_LENGTH / 4);
  localparam logic [31:0] DEPTH32      = 32'(FIFO_DEPTH);
  localparam logic [31:0] BURST32      = 32'(BURST_LENGTH);

  typedef enum logic [3:0] {
    IDLE       = 4'd0,
    FETCH      = 4'd1,
    REQ        = 4'd2,
    DONE_FETCH = 4'd3,
    DRAIN      = 4'd4
  } state_t;

  state_t state, state_next;

  logic [31:0]   words_remaining;
  logic [31:0]   pixels_left;
  logic [CW-1:0] pending;
  logic [CW-1:0] fifo_count;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          half_sel;
  // Only the 24 colour bits of each half are stored; the top byte of each
  // half carries no pixel information.
  logic [47:0]   fifo_mem [2**AW];

  logic [31:0] burst_words;
  logic [31:0] credit;
  logic        space_ok;
  logic        bus_idle;
  logic        accept;
  logic        beat;
  logic        push;
  logic        pop;
  logic        consume;
  logic        last_burst;
  logic        issue;
  logic        advance;
  logic        init;
  logic [23:0] pixel;
  logic        unused_bits;

  assign unused_bits = ^{readdata[63:56], readdata[31:24]};

  assign burst_words = (words_remaining < BURST32) ? words_remaining : BURST32;
  assign credit      = 32'(fifo_count) + 32'(pending);
  assign space_ok    = (credit + burst_words) <= DEPTH32;
  assign bus_idle    = (pending == '0) && !read;
  assign accept      = read && !waitrequest;
  // A beat with nothing outstanding is a leftover from before a reset.
  assign beat        = readdatavalid && (pending != '0);
  assign push        = beat && (state != DRAIN);
  assign last_burst  = (words_remaining == 32'(burstcount));

  assign pixel_valid = (fifo_count != '0) && (pixels_left != '0) && (state != DRAIN);
  assign consume     = pixel_valid && pixel_ready;
  assign pop         = consume && half_sel;
  assign pixel       = half_sel ? fifo_mem[rd_ptr][47:24] : fifo_mem[rd_ptr][23:0];
  assign red         = pixel[7:0];
  assign green       = pixel[15:8];
  assign blue        = pixel[23:16];

  assign debug_value0 = {underflow, 3'b000, state, 8'(fifo_count), words_remaining[15:0]};

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // A restart can only reinitialise once the bus is quiet; otherwise beats
  // of the old frame would land in the new frame's FIFO, so DRAIN absorbs them.
  always_comb begin
    state_next = state;
    issue      = 1'b0;
    advance    = 1'b0;
    init       = 1'b0;
    if (frame_start && (state != DRAIN)) begin
      if (bus_idle) begin
        init       = 1'b1;
        state_next = FETCH;
      end else begin
        state_next = DRAIN;
      end
    end else begin
      case (state)
        FETCH: begin
          if ((words_remaining != '0) && space_ok) begin
            issue      = 1'b1;
            state_next = REQ;
          end
        end
        REQ: begin
          if (accept) begin
            advance    = 1'b1;
            state_next = last_burst ? DONE_FETCH : FETCH;
          end
        end
        DRAIN: begin
          if (bus_idle) begin
            init       = 1'b1;
            state_next = FETCH;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      read            <= 1'b0;
      address         <= '0;
      burstcount      <= '0;
      words_remaining <= '0;
      pixels_left     <= '0;
      pending         <= '0;
      fifo_count      <= '0;
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      half_sel        <= 1'b0;
      underflow       <= 1'b0;
    end else if (init) begin
      address         <= BASE_WORD;
      words_remaining <= FRAME_WORDS;
      pixels_left     <= FRAME_PIXELS;
      fifo_count      <= '0;
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      half_sel        <= 1'b0;
      underflow       <= 1'b0;
    end else begin
      if (issue) begin
        read       <= 1'b1;
        burstcount <= 8'(burst_words);
      end else if (accept) begin
        read <= 1'b0;
      end
      // The address stops on the last burst so it never points past the buffer.
      if (advance) begin
        words_remaining <= words_remaining - 32'(burstcount);
        if (!last_burst) address <= address + 29'(burstcount);
      end
      // Pending is charged at issue time so credit already covers the burst.
      pending <= pending + (issue ? CW'(burst_words) : CW'(0)) - (beat ? CW'(1) : CW'(0));
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      fifo_count <= fifo_count + CW'(push) - CW'(pop);
      if (consume) begin
        pixels_left <= pixels_left - 32'd1;
        half_sel    <= ~half_sel;
      end
      if (frame_start)
        underflow <= 1'b0;
      else if (pixel_ready && !pixel_valid && (pixels_left != '0) && (state != IDLE))
        underflow <= 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (push) fifo_mem[wr_ptr] <= {readdata[55:32], readdata[23:0]};
  end

endmodule

// File: tb/tb_frame_buffer_reader.sv
`timescale 1ns/1ps
// Testbench for frame_buffer_reader. Two instances share clock and reset:
// dut_a reads a 256-byte frame, dut_b a 96-byte frame (short last burst).
// Each has its own Avalon memory model with one-cycle read latency.
module tb_frame_buffer_reader;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset_n;
  logic [28:0] address_s       [2];
  logic [7:0]  burstcount_s    [2];
  logic        waitrequest_s   [2];
  logic [63:0] readdata_s      [2];
  logic        readdatavalid_s [2];
  logic        read_s          [2];
  logic        frame_start_s   [2];
  logic        pixel_ready_s   [2];
  logic        pixel_valid_s   [2];
  logic [7:0]  red_s           [2];
  logic [7:0]  green_s         [2];
  logic [7:0]  blue_s          [2];
  logic        underflow_s     [2];
  logic [31:0] debug_s         [2];

  logic        stall_data [2];
  int          wait_req_n [2];
  int          acc_count  [2];
  int          stalls_done[2];
  int          acc_words  [2];
  int          cons_count [2];
  int          max_credit [2];
  int          acc_addr   [2][16];
  int          acc_bc     [2][16];
  logic [28:0] q0[$];
  logic [28:0] q1[$];

  int errors = 0;
  int checks = 0;

  frame_buffer_reader #(.FB_ADDRESS(32'h1000), .FB_LENGTH(256), .BURST_LENGTH(8), .FIFO_DEPTH(16)) dut_a (
    .clock(clock), .reset_n(reset_n), .address(address_s[0]), .burstcount(burstcount_s[0]),
    .waitrequest(waitrequest_s[0]), .readdata(readdata_s[0]), .readdatavalid(readdatavalid_s[0]),
    .read(read_s[0]), .frame_start(frame_start_s[0]), .pixel_ready(pixel_ready_s[0]),
    .pixel_valid(pixel_valid_s[0]), .red(red_s[0]), .green(green_s[0]), .blue(blue_s[0]),
    .underflow(underflow_s[0]), .debug_value0(debug_s[0]));

  frame_buffer_reader #(.FB_ADDRESS(32'h1000), .FB_LENGTH(96), .BURST_LENGTH(8), .FIFO_DEPTH(16)) dut_b (
    .clock(clock), .reset_n(reset_n), .address(address_s[1]), .burstcount(burstcount_s[1]),
    .waitrequest(waitrequest_s[1]), .readdata(readdata_s[1]), .readdatavalid(readdatavalid_s[1]),
    .read(read_s[1]), .frame_start(frame_start_s[1]), .pixel_ready(pixel_ready_s[1]),
    .pixel_valid(pixel_valid_s[1]), .red(red_s[1]), .green(green_s[1]), .blue(blue_s[1]),
    .underflow(underflow_s[1]), .debug_value0(debug_s[1]));

  // Memory contents: word 0x200 holds the hand-picked pattern, others derive from the address.
  function automatic logic [63:0] mem_word(input logic [28:0] a);
    logic [7:0] lo;
    lo = a[7:0];
    if (a == 29'h200) return 64'h00332211_00665544;
    return {8'hEE, lo ^ 8'hC3, 8'h77, ~lo, 8'hDD, 8'h5A, lo + 8'h01, lo};
  endfunction

  // Expected {blue, green, red} of pixel k of a frame starting at word 0x200.
  function automatic logic [23:0] exp_pixel(input int k);
    logic [63:0] w;
    w = mem_word(29'(32'h200 + k / 2));
    return ((k % 2) == 1) ? w[55:32] : w[23:0];
  endfunction

  // Avalon slave model for instance g, evaluated just after each falling edge.
  task automatic slave_step(input int g);
    logic [28:0] a;
    int qs;
    int credit;
    if (!reset_n) begin
      if (g == 0) q0.delete(); else q1.delete();
      readdatavalid_s[g] = 1'b0;
      readdata_s[g]      = '0;
      waitrequest_s[g]   = 1'b0;
      acc_count[g]       = 0;
      stalls_done[g]     = 0;
      acc_words[g]       = 0;
      cons_count[g]      = 0;
      max_credit[g]      = 0;
      return;
    end
    qs = (g == 0) ? q0.size() : q1.size();
    readdatavalid_s[g] = 1'b0;
    if (!stall_data[g] && qs > 0) begin
      a = (g == 0) ? q0.pop_front() : q1.pop_front();
      readdatavalid_s[g] = 1'b1;
      readdata_s[g]      = mem_word(a);
    end
    waitrequest_s[g] = 1'b0;
    if (read_s[g] === 1'b1) begin
      if (stalls_done[g] < wait_req_n[g]) begin
        waitrequest_s[g] = 1'b1;
        stalls_done[g]++;
      end else begin
        for (int i = 0; i < int'(burstcount_s[g]); i++) begin
          if (g == 0) q0.push_back(address_s[g] + 29'(i));
          else        q1.push_back(address_s[g] + 29'(i));
        end
        if (acc_count[g] < 16) begin
          acc_addr[g][acc_count[g]] = int'(address_s[g]);
          acc_bc[g][acc_count[g]]   = int'(burstcount_s[g]);
        end
        acc_count[g]++;
        acc_words[g] += int'(burstcount_s[g]);
      end
    end
    if (pixel_valid_s[g] === 1'b1 && pixel_ready_s[g] === 1'b1) cons_count[g]++;
    credit = acc_words[g] - cons_count[g] / 2;
    if (credit > max_credit[g]) max_credit[g] = credit;
  endtask

  always begin
    @(negedge clock);
    #1;
    for (int g = 0; g < 2; g++) slave_step(g);
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1, "[TB] watchdog");
  end

  task automatic do_reset();
    reset_n = 1'b0;
    for (int g = 0; g < 2; g++) begin
      frame_start_s[g] = 1'b0;
      pixel_ready_s[g] = 1'b0;
      stall_data[g]    = 1'b0;
      wait_req_n[g]    = 0;
    end
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
  endtask

  task automatic pulse_frame(input int g);
    @(negedge clock);
    frame_start_s[g] = 1'b1;
    @(negedge clock);
    frame_start_s[g] = 1'b0;
  endtask

  // Consume n pixels on instance g, checking each against the model from index first.
  task automatic consume_pixels(input int g, input int n, input int first);
    int cnt = 0;
    int t = 0;
    logic [23:0] exp;
    while (cnt < n && t < 2000) begin
      @(negedge clock);
      t++;
      pixel_ready_s[g] = 1'b1;
      if (pixel_valid_s[g] === 1'b1) begin
        exp = exp_pixel(first + cnt);
        checks++;
        if ({blue_s[g], green_s[g], red_s[g]} !== exp) begin
          errors++;
          $display("[TB] FAIL pixel[%0d] inst %0d: got bgr=%h expected %h", first + cnt, g,
                   {blue_s[g], green_s[g], red_s[g]}, exp);
        end
        cnt++;
      end
    end
    @(negedge clock);
    pixel_ready_s[g] = 1'b0;
    checks++;
    if (cnt != n) begin
      errors++;
      $display("[TB] FAIL consume_timeout inst %0d: got %0d pixels expected %0d", g, cnt, n);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    for (int g = 0; g < 2; g++) begin
      frame_start_s[g] = 1'b0;
      pixel_ready_s[g] = 1'b0;
      stall_data[g]    = 1'b0;
      wait_req_n[g]    = 0;
    end
    repeat (2) @(negedge clock);
    for (int g = 0; g < 2; g++) begin
      checks++;
      if (read_s[g] !== 1'b0 || pixel_valid_s[g] !== 1'b0 || underflow_s[g] !== 1'b0) begin
        errors++;
        $display("[TB] FAIL reset_flags inst %0d: got read=%b valid=%b underflow=%b expected 0/0/0",
                 g, read_s[g], pixel_valid_s[g], underflow_s[g]);
      end
      checks++;
      if (address_s[g] !== 29'h0 || burstcount_s[g] !== 8'h0) begin
        errors++;
        $display("[TB] FAIL reset_addr inst %0d: got address=%h burstcount=%0d expected 0/0",
                 g, address_s[g], burstcount_s[g]);
      end
      checks++;
      if (debug_s[g] !== 32'h0) begin
        errors++;
        $display("[TB] FAIL reset_debug inst %0d: got %h expected 00000000", g, debug_s[g]);
      end
    end
    reset_n = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_backpressure();
    do_reset();
    pulse_frame(0);
    repeat (40) @(negedge clock);
    checks++;
    if (acc_count[0] !== 2) begin
      errors++;
      $display("[TB] FAIL bp_burst_count: got %0d bursts expected 2", acc_count[0]);
    end
    checks++;
    if (acc_addr[0][0] !== 32'h200 || acc_bc[0][0] !== 8 || acc_addr[0][1] !== 32'h208 || acc_bc[0][1] !== 8) begin
      errors++;
      $display("[TB] FAIL bp_bursts: got %h/%0d %h/%0d expected 200/8 208/8",
               acc_addr[0][0], acc_bc[0][0], acc_addr[0][1], acc_bc[0][1]);
    end
    checks++;
    if (read_s[0] !== 1'b0 || debug_s[0][23:16] !== 8'd16) begin
      errors++;
      $display("[TB] FAIL bp_full: got read=%b fifo_count=%0d expected 0/16", read_s[0], debug_s[0][23:16]);
    end
    checks++;
    if (underflow_s[0] !== 1'b0) begin
      errors++;
      $display("[TB] FAIL bp_underflow: got %b expected 0", underflow_s[0]);
    end
  endtask

  task automatic test_pixel_format();
    checks++;
    if (pixel_valid_s[0] !== 1'b1 || red_s[0] !== 8'h44 || green_s[0] !== 8'h55 || blue_s[0] !== 8'h66) begin
      errors++;
      $display("[TB] FAIL fmt_low: got valid=%b r=%h g=%h b=%h expected 1 44 55 66",
               pixel_valid_s[0], red_s[0], green_s[0], blue_s[0]);
    end
    consume_pixels(0, 1, 0);
    checks++;
    if (pixel_valid_s[0] !== 1'b1 || red_s[0] !== 8'h11 || green_s[0] !== 8'h22 || blue_s[0] !== 8'h33) begin
      errors++;
      $display("[TB] FAIL fmt_high: got valid=%b r=%h g=%h b=%h expected 1 11 22 33",
               pixel_valid_s[0], red_s[0], green_s[0], blue_s[0]);
    end
  endtask

  task automatic test_full_frame();
    int extra = 0;
    consume_pixels(0, 63, 1);
    checks++;
    if (acc_count[0] !== 4 || acc_addr[0][2] !== 32'h210 || acc_bc[0][2] !== 8 ||
        acc_addr[0][3] !== 32'h218 || acc_bc[0][3] !== 8) begin
      errors++;
      $display("[TB] FAIL frame_bursts: got n=%0d %h/%0d %h/%0d expected 4 210/8 218/8",
               acc_count[0], acc_addr[0][2], acc_bc[0][2], acc_addr[0][3], acc_bc[0][3]);
    end
    checks++;
    if (max_credit[0] > 16) begin
      errors++;
      $display("[TB] FAIL frame_credit: got max %0d expected <= 16", max_credit[0]);
    end
    pixel_ready_s[0] = 1'b1;
    repeat (10) begin
      @(negedge clock);
      if (pixel_valid_s[0] !== 1'b0) extra++;
    end
    pixel_ready_s[0] = 1'b0;
    checks++;
    if (extra != 0 || underflow_s[0] !== 1'b0 || debug_s[0][27:24] !== 4'd3) begin
      errors++;
      $display("[TB] FAIL frame_end: got valid_cycles=%0d underflow=%b state=%0d expected 0 0 3",
               extra, underflow_s[0], debug_s[0][27:24]);
    end
  endtask

  task automatic test_waitrequest();
    int rc = 0;
    int bad = 0;
    int t = 0;
    do_reset();
    wait_req_n[0] = 5;
    pulse_frame(0);
    while (t < 30) begin
      @(negedge clock);
      t++;
      if (read_s[0] === 1'b1) begin
        rc++;
        if (address_s[0] !== 29'h200 || burstcount_s[0] !== 8'd8) bad++;
      end else if (rc > 0) begin
        break;
      end
    end
    checks++;
    if (rc != 6 || bad != 0) begin
      errors++;
      $display("[TB] FAIL wait_hold: got read_cycles=%0d unstable=%0d expected 6 0", rc, bad);
    end
    checks++;
    if (acc_count[0] !== 1 || acc_addr[0][0] !== 32'h200) begin
      errors++;
      $display("[TB] FAIL wait_accept: got n=%0d addr=%h expected 1 200", acc_count[0], acc_addr[0][0]);
    end
    repeat (10) @(negedge clock);
    checks++;
    if (acc_count[0] < 2 || acc_addr[0][1] !== 32'h208) begin
      errors++;
      $display("[TB] FAIL wait_next: got n=%0d addr=%h expected >=2 208", acc_count[0], acc_addr[0][1]);
    end
    wait_req_n[0] = 0;
  endtask

  task automatic test_restart();
    int t = 0;
    do_reset();
    @(negedge clock);
    frame_start_s[0] = 1'b1;
    @(negedge clock);
    frame_start_s[0] = 1'b0;
    pixel_ready_s[0] = 1'b1;
    @(negedge clock);
    pixel_ready_s[0] = 1'b0;
    checks++;
    if (underflow_s[0] !== 1'b1) begin
      errors++;
      $display("[TB] FAIL restart_underflow_set: got %b expected 1", underflow_s[0]);
    end
    repeat (40) @(negedge clock);
    stall_data[0] = 1'b1;
    consume_pixels(0, 16, 0);
    while (acc_count[0] < 3 && t < 60) begin
      @(negedge clock);
      t++;
    end
    repeat (5) @(negedge clock);
    checks++;
    if (acc_count[0] !== 3 || acc_addr[0][2] !== 32'h210 || read_s[0] !== 1'b0 || debug_s[0][23:16] !== 8'd8) begin
      errors++;
      $display("[TB] FAIL restart_setup: got n=%0d addr=%h read=%b fifo=%0d expected 3 210 0 8",
               acc_count[0], acc_addr[0][2], read_s[0], debug_s[0][23:16]);
    end
    pulse_frame(0);
    checks++;
    if (debug_s[0][27:24] !== 4'd4 || underflow_s[0] !== 1'b0 || pixel_valid_s[0] !== 1'b0) begin
      errors++;
      $display("[TB] FAIL restart_drain: got state=%0d underflow=%b valid=%b expected 4 0 0",
               debug_s[0][27:24], underflow_s[0], pixel_valid_s[0]);
    end
    stall_data[0] = 1'b0;
    t = 0;
    while (acc_count[0] < 4 && t < 80) begin
      @(negedge clock);
      t++;
    end
    checks++;
    if (acc_count[0] !== 4 || acc_addr[0][3] !== 32'h200 || acc_bc[0][3] !== 8) begin
      errors++;
      $display("[TB] FAIL restart_request: got n=%0d addr=%h bc=%0d expected 4 200 8",
               acc_count[0], acc_addr[0][3], acc_bc[0][3]);
    end
    t = 0;
    while (pixel_valid_s[0] !== 1'b1 && t < 20) begin
      @(negedge clock);
      t++;
    end
    checks++;
    if (pixel_valid_s[0] !== 1'b1 || {blue_s[0], green_s[0], red_s[0]} !== 24'h665544 || underflow_s[0] !== 1'b0) begin
      errors++;
      $display("[TB] FAIL restart_first_pixel: got valid=%b bgr=%h underflow=%b expected 1 665544 0",
               pixel_valid_s[0], {blue_s[0], green_s[0], red_s[0]}, underflow_s[0]);
    end
  endtask

  task automatic test_short_frame();
    int extra = 0;
    do_reset();
    pulse_frame(1);
    repeat (30) @(negedge clock);
    checks++;
    if (acc_count[1] !== 2 || acc_addr[1][0] !== 32'h200 || acc_bc[1][0] !== 8 ||
        acc_addr[1][1] !== 32'h208 || acc_bc[1][1] !== 4) begin
      errors++;
      $display("[TB] FAIL short_bursts: got n=%0d %h/%0d %h/%0d expected 2 200/8 208/4",
               acc_count[1], acc_addr[1][0], acc_bc[1][0], acc_addr[1][1], acc_bc[1][1]);
    end
    checks++;
    if (address_s[1] > 29'h20B || debug_s[1][23:16] !== 8'd12) begin
      errors++;
      $display("[TB] FAIL short_addr: got address=%h fifo=%0d expected <=20b 12",
               address_s[1], debug_s[1][23:16]);
    end
    consume_pixels(1, 24, 0);
    pixel_ready_s[1] = 1'b1;
    repeat (10) begin
      @(negedge clock);
      if (pixel_valid_s[1] !== 1'b0) extra++;
    end
    pixel_ready_s[1] = 1'b0;
    checks++;
    if (extra != 0 || underflow_s[1] !== 1'b0 || debug_s[1][27:24] !== 4'd3) begin
      errors++;
      $display("[TB] FAIL short_end: got valid_cycles=%0d underflow=%b state=%0d expected 0 0 3",
               extra, underflow_s[1], debug_s[1][27:24]);
    end
  endtask

  initial begin
    $display("[TB] frame_buffer_reader bench start");
    test_reset();
    test_backpressure();
    test_pixel_format();
    test_full_frame();
    test_waitrequest();
    test_restart();
    test_short_frame();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
